// File: rtl/i2c_slave_regfile_if.sv
// Byte-level link between the I2C slave engine and the register-file controller.
// The engine is the master side; the register file is the slave side.
interface i2c_slave_regfile_if;
    logic       busStart;
    logic [7:0] datareceive;
    logic       received;
    logic       sended;
    logic [7:0] datasend;
    logic [6:0] address;
    logic       addressLatch;

    modport master (
        output busStart, datareceive, received, sended,
        input  datasend, address, addressLatch
    );

    modport slave (
        input  busStart, datareceive, received, sended,
        output datasend, address, addressLatch
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C register map: pointer byte then auto-incrementing data bytes, shared with a host port.
// Define I2C_REGFILE_WRAP_EN for modulo pointer wrap; otherwise the pointer saturates.
module i2c_slave_regfile #(
    parameter int         REG_COUNT       = 16,
    parameter int         PTR_W           = 4,
    parameter logic [6:0] DEFAULT_ADDRESS = 7'h3C
) (
    input  logic             clk,
    input  logic             reset,
    i2c_slave_regfile_if.slave bus,
    input  logic [6:0]       cfg_address,
    input  logic             cfg_load,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             bus_wr,
    output logic [PTR_W-1:0] bus_wr_idx,
    output logic             collision
);
    localparam logic [1:0] LATCH    = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] WAIT_PTR = 2'd2;
    localparam logic [1:0] DATA     = 2'd3;

    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(REG_COUNT - 1);

    logic [1:0]       state, state_next;
    logic [1:0]       lcnt;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic             rx_q, tx_q;
    logic             rx_evt, tx_evt;
    logic             wr_en;
    logic [7:0]       regs [REG_COUNT];

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
`ifdef I2C_REGFILE_WRAP_EN
        return p + PTR_W'(1);
`else
        return (p == PTR_MAX) ? p : p + PTR_W'(1);
`endif
    endfunction

    assign rx_evt = rx_q & ~bus.received;
    assign tx_evt = tx_q & ~bus.sended;

    // rx wins over tx; a START in DATA preempts both
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        wr_en      = 1'b0;
        if (cfg_load) begin
            state_next = LATCH;
        end else begin
            unique case (state)
                LATCH: if (lcnt == 2'd2) state_next = IDLE;
                IDLE:  if (bus.busStart) state_next = WAIT_PTR;
                WAIT_PTR: begin
                    if (rx_evt) begin
                        ptr_next   = bus.datareceive[PTR_W-1:0];
                        state_next = DATA;
                    end else if (tx_evt) begin
                        ptr_next   = inc(ptr);
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bus.busStart) begin
                        state_next = WAIT_PTR;
                    end else if (rx_evt) begin
                        wr_en    = 1'b1;
                        ptr_next = inc(ptr);
                    end else if (tx_evt) begin
                        ptr_next = inc(ptr);
                    end
                end
                default: state_next = LATCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= LATCH;
            lcnt             <= 2'd0;
            ptr              <= '0;
            rx_q             <= 1'b1;
            tx_q             <= 1'b1;
            bus.address      <= DEFAULT_ADDRESS;
            bus.addressLatch <= 1'b1;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            rx_q  <= bus.received;
            tx_q  <= bus.sended;
            if (cfg_load) begin
                bus.address      <= cfg_address;
                bus.addressLatch <= 1'b0;
                lcnt             <= 2'd1;
            end else if (state == LATCH) begin
                if (lcnt == 2'd2) begin
                    bus.addressLatch <= 1'b1;
                end else begin
                    bus.addressLatch <= 1'b0;
                    lcnt             <= lcnt + 2'd1;
                end
            end
        end
    end

    // bus write beats a host write to the same index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_en && ptr == PTR_W'(i))
                    regs[i] <= bus.datareceive;
                else if (host_we && host_addr == PTR_W'(i))
                    regs[i] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.datasend <= 8'h00;
            host_rdata   <= 8'h00;
            bus_wr       <= 1'b0;
            bus_wr_idx   <= '0;
            collision    <= 1'b0;
        end else begin
            bus.datasend <= regs[ptr_next];
            host_rdata   <= regs[host_addr];
            bus_wr       <= wr_en;
            if (wr_en) bus_wr_idx <= ptr;
            collision    <= wr_en && host_we && (host_addr == ptr);
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: vector table plus hand-written corner sequences.
// Expectations follow I2C_REGFILE_WRAP_EN the same way the design does.
module tb_i2c_slave_regfile;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] cfg_address;
    logic       cfg_load;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       bus_wr;
    logic [3:0] bus_wr_idx;
    logic       collision;

    int checks = 0;
    int errors = 0;

    i2c_slave_regfile_if bif();

    i2c_slave_regfile #(
        .REG_COUNT(16), .PTR_W(4), .DEFAULT_ADDRESS(7'h3C)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif),
        .cfg_address(cfg_address), .cfg_load(cfg_load),
        .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .bus_wr(bus_wr), .bus_wr_idx(bus_wr_idx),
        .collision(collision)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_RX    = 2'd1;
    localparam logic [1:0] OP_TX    = 2'd2;

    typedef struct {
        logic [1:0] op;
        logic [7:0] din;
        logic [7:0] ds;
        logic [3:0] ptr;
        logic       bw;
        logic [3:0] idx;
    } vec_t;

    vec_t tv [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic count_low(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!bif.addressLatch) c++;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] din);
        unique case (op)
            OP_START: bif.busStart = 1'b1;
            OP_RX: begin
                bif.datareceive = din;
                bif.received    = 1'b0;
            end
            default: bif.sended = 1'b0;
        endcase
        tick();
        bif.busStart = 1'b0;
        bif.received = 1'b1;
        bif.sended   = 1'b1;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp,
                             input string name);
        host_addr = a;
        tick();
        chk(name, host_rdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset           = 1'b0;
        bif.busStart    = 1'b0;
        bif.datareceive = 8'h00;
        bif.received    = 1'b1;
        bif.sended      = 1'b1;
        cfg_address     = 7'h00;
        cfg_load        = 1'b0;
        host_we         = 1'b0;
        host_addr       = 4'd0;
        host_wdata      = 8'h00;

        tv[0] = '{OP_START, 8'h00, 8'h00, 4'd0, 1'b0, 4'd0};
        tv[1] = '{OP_RX,    8'h02, 8'h00, 4'd2, 1'b0, 4'd0};
        tv[2] = '{OP_RX,    8'hAA, 8'h00, 4'd3, 1'b1, 4'd2};
        tv[3] = '{OP_RX,    8'h55, 8'h00, 4'd4, 1'b1, 4'd3};
        tv[4] = '{OP_START, 8'h00, 8'h00, 4'd4, 1'b0, 4'd0};
        tv[5] = '{OP_RX,    8'h02, 8'hAA, 4'd2, 1'b0, 4'd0};
        tv[6] = '{OP_START, 8'h00, 8'hAA, 4'd2, 1'b0, 4'd0};
        tv[7] = '{OP_TX,    8'h00, 8'h55, 4'd3, 1'b0, 4'd0};
        tv[8] = '{OP_TX,    8'h00, 8'h00, 4'd4, 1'b0, 4'd0};
        tv[9] = '{OP_TX,    8'h00, 8'h00, 4'd5, 1'b0, 4'd0};

        tick(); tick();
        chk("rst_address", bif.address, 7'h3C);
        chk("rst_latch", bif.addressLatch, 1'b1);
        chk("rst_datasend", bif.datasend, 8'h00);
        chk("rst_host_rdata", host_rdata, 8'h00);
        chk("rst_bus_wr", bus_wr, 1'b0);
        chk("rst_bus_wr_idx", bus_wr_idx, 4'd0);
        chk("rst_collision", collision, 1'b0);
        reset = 1'b1;
        count_low(6, c);
        chk("latch_low_cycles", c, 2);
        chk("latch_end_high", bif.addressLatch, 1'b1);

        cfg_address = 7'h50;
        cfg_load    = 1'b1;
        tick();
        cfg_load = 1'b0;
        chk("cfg_latch_low", bif.addressLatch, 1'b0);
        chk("cfg_address", bif.address, 7'h50);
        count_low(5, c);
        chk("cfg_low_cycles", c + 1, 2);
        chk("cfg_end_high", bif.addressLatch, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_op(tv[i].op, tv[i].din);
            chk($sformatf("vec%0d_bus_wr", i), bus_wr, tv[i].bw);
            if (tv[i].bw)
                chk($sformatf("vec%0d_idx", i), bus_wr_idx, tv[i].idx);
            tick();
            chk($sformatf("vec%0d_bus_wr_done", i), bus_wr, 1'b0);
            chk($sformatf("vec%0d_ptr", i), dut.ptr, tv[i].ptr);
            chk($sformatf("vec%0d_datasend", i), bif.datasend, tv[i].ds);
        end
        host_read(4'd2, 8'hAA, "reg2");
        host_read(4'd3, 8'h55, "reg3");

        do_op(OP_START, 8'h00); tick();
        do_op(OP_RX, 8'h0F); tick();
        do_op(OP_RX, 8'h11); tick();
        do_op(OP_RX, 8'h22); tick();
`ifdef I2C_REGFILE_WRAP_EN
        host_read(4'd15, 8'h11, "wrap_reg15");
        host_read(4'd0, 8'h22, "wrap_reg0");
        chk("wrap_ptr", dut.ptr, 4'd1);
`else
        host_read(4'd15, 8'h22, "sat_reg15");
        host_read(4'd0, 8'h00, "sat_reg0");
        chk("sat_ptr", dut.ptr, 4'd15);
`endif

        do_op(OP_START, 8'h00); tick();
        do_op(OP_RX, 8'h05); tick();
        bif.datareceive = 8'h99;
        bif.received    = 1'b0;
        host_we    = 1'b1;
        host_addr  = 4'd5;
        host_wdata = 8'h77;
        tick();
        bif.received = 1'b1;
        host_we      = 1'b0;
        chk("coll_pulse", collision, 1'b1);
        tick();
        chk("coll_once", collision, 1'b0);
        host_read(4'd5, 8'h99, "coll_reg5");

        do_op(OP_START, 8'h00); tick();
        do_op(OP_RX, 8'h05); tick();
        bif.datareceive = 8'h99;
        bif.received    = 1'b0;
        host_we    = 1'b1;
        host_addr  = 4'd6;
        host_wdata = 8'h77;
        tick();
        bif.received = 1'b1;
        host_we      = 1'b0;
        chk("nocoll_pulse", collision, 1'b0);
        tick();
        host_read(4'd6, 8'h77, "nocoll_reg6");
        host_read(4'd5, 8'h99, "nocoll_reg5");

        do_op(OP_START, 8'h00); tick();
        do_op(OP_RX, 8'h07); tick();
        chk("pre_rst_ptr", dut.ptr, 4'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ptr", dut.ptr, 4'd0);
        chk("arst_datasend", bif.datasend, 8'h00);
        chk("arst_address", bif.address, 7'h3C);
        chk("arst_latch", bif.addressLatch, 1'b1);
        chk("arst_reg5", dut.regs[5], 8'h00);
        tick(); tick();
        reset = 1'b1;
        count_low(6, c);
        chk("rerun_latch_cycles", c, 2);
        for (int i = 0; i < 16; i++)
            host_read(4'(i), 8'h00, $sformatf("cleared_reg%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Register-file controller that sits behind the I2C slave byte engine. It configures the slave's 7-bit device address, turns the slave's received-byte and send-request strobes into register-pointer, write and read sequencing, and shares the register array with a local host port. The result is a standard "pointer byte then data bytes, auto-increment" I2C register map.

## Interface

Parameters:
- REG_COUNT, 16: number of 8-bit registers; must be a power of two, 2..256.
- PTR_W, 4: pointer width; must equal log2(REG_COUNT).
- DEFAULT_ADDRESS, 7'h3C: device address loaded after reset.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- reset  in  1  asynchronous, active-low reset.
- busStart  in  1  one-cycle high pulse on every START or repeated START.
- datareceive  in  8  byte from the slave; valid while `received` is low.
- received  in  1  active-low level; its falling edge marks a new data byte. It never asserts for the address byte.
- sended  in  1  active-low level; its falling edge means the slave consumed `datasend` and needs the next byte.
- datasend  out  8  byte offered to the slave for reads.
- address  out  7  device address driven to the slave.
- addressLatch  out  1  active-low load strobe for `address`.
- cfg_address  in  7  new device address.
- cfg_load  in  1  one-cycle pulse that reloads `address` from `cfg_address`.
- host_we  in  1  host write enable.
- host_addr  in  PTR_W  host register index.
- host_wdata  in  8  host write data.
- host_rdata  out  8  registered read of regs[host_addr].
- bus_wr  out  1  one-cycle pulse when an I2C write updates a register.
- bus_wr_idx  out  PTR_W  index written on `bus_wr`.
- collision  out  1  one-cycle pulse when a host write lost to a bus write.

## Operation

Reset values:
- regs: all 0.
- ptr: 0.
- datasend: 0.
- address: DEFAULT_ADDRESS.
- addressLatch: 1.
- host_rdata, bus_wr, bus_wr_idx, collision: 0.
- FSM: LATCH.

Edge detection:
- `received` and `sended` are registered into `rx_q` and `tx_q`; both reset to 1.
- rx_evt = rx_q & ~received; tx_evt = tx_q & ~sended.

FSM states:
- LATCH: drive addressLatch low for exactly 2 cycles with `address` stable, then go to IDLE. cfg_load in any state loads `address` <= cfg_address and enters LATCH.
- IDLE: busStart -> WAIT_PTR.
- WAIT_PTR: rx_evt -> ptr <= datareceive[PTR_W-1:0], go to DATA. tx_evt -> read from the current ptr; ptr++ and go to DATA. busStart -> stay in WAIT_PTR.
- DATA: rx_evt -> regs[ptr] <= datareceive, bus_wr=1, bus_wr_idx=ptr, ptr++. tx_evt -> ptr++. busStart -> WAIT_PTR; ptr is kept, so a repeated-START read starts at the last pointer.

Event rules:
- rx_evt and tx_evt in the same cycle: rx_evt wins and tx_evt is dropped.
- rx_evt or tx_evt in LATCH or IDLE is ignored.

datasend:
- Registered; datasend <= regs[ptr_next] every cycle, where ptr_next is the pointer value after this cycle's update.

Host port:
- host_rdata <= regs[host_addr] every cycle.
- host_we writes regs[host_addr] <= host_wdata.
- If a bus write hits the same index in the same cycle, the bus write wins and collision pulses. A host write to a different index completes normally in the same cycle.

## Timing

- rx_evt is detected at posedge N, the first posedge that samples `received` low. The register is written and ptr updated at posedge N, and `bus_wr` is high during cycle N..N+1.
- tx_evt detected at posedge N: ptr increments at N, and datasend holds regs[new ptr] from posedge N onward. The slave must sample datasend ≥1 cycle after lowering `sended`.
- Pointer wrap: see Configuration.
- cfg_load during LATCH restarts the 2-cycle strobe with the new address.
- Asynchronous reset mid-transfer returns everything to reset values immediately. LATCH runs again after reset is released.

## Configuration

- I2C_REGFILE_WRAP_EN defined: ptr increments modulo REG_COUNT, so REG_COUNT-1 wraps to 0.
- Not defined: ptr saturates at REG_COUNT-1.
  - Further bus writes keep overwriting register REG_COUNT-1.
  - Further reads keep returning register REG_COUNT-1.

## Test plan

- Reset release with DEFAULT_ADDRESS=7'h3C -> address=7'h3C and addressLatch low for exactly 2 cycles, then high. A later cfg_load with cfg_address=7'h50 -> address=7'h50 and a new 2-cycle low strobe.
- busStart, then received strobes with 8'h02, 8'hAA, 8'h55 -> regs[2]=AA, regs[3]=55, ptr=4, two bus_wr pulses with idx 2 and 3.
- After that write, busStart and three sended falling edges -> datasend shows AA after the repeated START with pointer 2, then 55, then regs[4].
- Pointer byte 8'h0F, then writes 11 and 22 -> with I2C_REGFILE_WRAP_EN: regs[15]=11, regs[0]=22. Without it: regs[15]=22 and ptr stays 15.
- Host write of 8'h77 to index 5 in the same cycle as a bus write of 8'h99 to index 5 -> regs[5]=99 and collision pulses once. The same test with host index 6 -> regs[6]=77 and no collision.
- Assert reset while in DATA with ptr=7 -> ptr=0, datasend=0, all registers 0, and LATCH runs again after reset is released.
